// File: rtl/fft_bitrev_buffer_if.sv
// Streaming sample bus between an FFT stage and the bit-reversal reorder buffer.
// The master drives samples in; the slave returns reordered samples.
interface fft_bitrev_buffer_if #(
    parameter int WIDTH = 36
);
    logic             i_ce;
    logic             i_sync;
    logic [WIDTH-1:0] i_data;
    logic [WIDTH-1:0] o_data;
    logic             o_sync;

    modport master (
        output i_ce, i_sync, i_data,
        input  o_data, o_sync
    );

    modport slave (
        input  i_ce, i_sync, i_data,
        output o_data, o_sync
    );
endinterface

// File: rtl/fft_bitrev_buffer.sv
// Double-buffered reorder stage: stores bit-reversed FFT frames in arrival order
// and reads the opposite bank in bit-reversed order so frames leave in natural order.
module fft_bitrev_buffer #(
    parameter int LGSIZE = 9,
    parameter int WIDTH  = 36
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    fft_bitrev_buffer_if.slave   bus
);
    localparam int N = 1 << LGSIZE;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        FILL,
        STREAM
    } state_t;

    state_t            state;
    logic [LGSIZE:0]   wcnt;
    logic [WIDTH-1:0]  mem [2*N];

    logic              advance;
    logic              wbank;
    logic [LGSIZE-1:0] wk;
    logic [LGSIZE-1:0] rk;
    logic [LGSIZE:0]   waddr;
    logic [LGSIZE:0]   raddr;

    // Until locked, only a sync-qualified strobe starts a frame at index 0.
    assign advance = bus.i_ce && ((state != WAIT_SYNC) || bus.i_sync);
    assign wbank   = wcnt[LGSIZE];
    assign wk      = wcnt[LGSIZE-1:0];

    for (genvar g = 0; g < LGSIZE; g++) begin : g_bitrev
        assign rk[g] = wk[LGSIZE-1-g];
    end

    assign waddr = {wbank, wk};
    assign raddr = {~wbank, rk};

    always_ff @(posedge i_clk) begin
        if (advance) begin
            mem[waddr] <= bus.i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= WAIT_SYNC;
            wcnt       <= '0;
            bus.o_data <= '0;
            bus.o_sync <= 1'b0;
        end else if (advance) begin
            wcnt <= wcnt + 1'b1;
            if (state == STREAM) begin
                bus.o_data <= mem[raddr];
                bus.o_sync <= (wk == '0);
            end else begin
                bus.o_data <= '0;
                bus.o_sync <= 1'b0;
            end
            case (state)
                WAIT_SYNC: state <= FILL;
                FILL:      if (wk == '1) state <= STREAM;
                STREAM:    state <= STREAM;
                default:   state <= WAIT_SYNC;
            endcase
        end
    end
endmodule
